risc_pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core, sitting beside the decode-stage control path.
//  - Carries decoded control through ID/EX, EX/MEM and MEM/WB registers.
//  - Detects load-use hazards and taken branches/jumps.
//  - Drives fetch/decode stall and flush, plus the EX operand forwarding selects.

---
 rtl/risc_pipe_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_risc_pipe_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/risc_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: ID/EX, EX/MEM, MEM/WB control registers,
// load-use / branch hazard handling and EX forwarding selects. Define RISC_PIPE_PERF_EN for perf counters.
module risc_pipe_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
`ifdef RISC_PIPE_PERF_EN
  output logic [PERF_W-1:0] stallCnt,
  output logic [PERF_W-1:0] flushCnt,
  output logic [PERF_W-1:0] retireCnt,
`endif
  input  logic              regWriteD,
  input  logic [1:0]        resultSrcD,
  input  logic              memWriteD,
  input  logic              branchD,
  input  logic              jumpD,
  input  logic [2:0]        aluControlD,
  input  logic              aluSrcD,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdD,
  input  logic              zeroE,
  output logic              regWriteE,
  output logic [1:0]        resultSrcE,
  output logic              memWriteE,
  output logic [2:0]        aluControlE,
  output logic              aluSrcE,
  output logic [REG_AW-1:0] rs1E,
  output logic [REG_AW-1:0] rs2E,
  output logic [REG_AW-1:0] rdE,
  output logic              regWriteM,
  output logic [1:0]        resultSrcM,
  output logic              memWriteM,
  output logic [REG_AW-1:0] rdM,
  output logic              regWriteW,
  output logic [1:0]        resultSrcW,
  output logic [REG_AW-1:0] rdW,
  output logic              pcSrcE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic              branch;
    logic              jump;
    logic [2:0]        alu_control;
    logic              alu_src;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
`ifdef RISC_PIPE_PERF_EN
    logic              vld;
`endif
  } idex_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic              mem_write;
    logic [REG_AW-1:0] rd;
`ifdef RISC_PIPE_PERF_EN
    logic              vld;
`endif
  } exmem_t;

  typedef struct packed {
    logic              reg_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
`ifdef RISC_PIPE_PERF_EN
    logic              vld;
`endif
  } memwb_t;

  idex_t  idex_d,  idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;
  logic   lw_stall, pc_src;

  // Hazards look only at registered EX state plus the D-stage source addresses.
  always_comb begin
    pc_src   = (idex_q.branch & zeroE) | idex_q.jump;
    lw_stall = (idex_q.result_src == 2'b01) && (idex_q.rd != '0) &&
               ((idex_q.rd == rs1D) || (idex_q.rd == rs2D));
  end

  always_comb begin
    idex_d = '0;
    if (!(lw_stall | pc_src)) begin
      idex_d.reg_write   = regWriteD;
      idex_d.result_src  = resultSrcD;
      idex_d.mem_write   = memWriteD;
      idex_d.branch      = branchD;
      idex_d.jump        = jumpD;
      idex_d.alu_control = aluControlD;
      idex_d.alu_src     = aluSrcD;
      idex_d.rs1         = rs1D;
      idex_d.rs2         = rs2D;
      idex_d.rd          = rdD;
`ifdef RISC_PIPE_PERF_EN
      idex_d.vld         = 1'b1;
`endif
    end
  end

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = idex_q.reg_write;
    exmem_d.result_src = idex_q.result_src;
    exmem_d.mem_write  = idex_q.mem_write;
    exmem_d.rd         = idex_q.rd;
`ifdef RISC_PIPE_PERF_EN
    exmem_d.vld        = idex_q.vld;
`endif
    memwb_d            = '0;
    memwb_d.reg_write  = exmem_q.reg_write;
    memwb_d.result_src = exmem_q.result_src;
    memwb_d.rd         = exmem_q.rd;
`ifdef RISC_PIPE_PERF_EN
    memwb_d.vld        = exmem_q.vld;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Per-operand forwarding: MEM beats WB, x0 is never forwarded.
  logic [1:0][REG_AW-1:0] rs_e;
  logic [1:0][1:0]        fwd;
  assign rs_e = {idex_q.rs2, idex_q.rs1};

  for (genvar op = 0; op < 2; op++) begin : g_fwd
    always_comb begin
      fwd[op] = 2'b00;
      if (exmem_q.reg_write && (exmem_q.rd != '0) && (exmem_q.rd == rs_e[op]))
        fwd[op] = 2'b10;
      else if (memwb_q.reg_write && (memwb_q.rd != '0) && (memwb_q.rd == rs_e[op]))
        fwd[op] = 2'b01;
    end
  end

  assign forwardAE = fwd[0];
  assign forwardBE = fwd[1];

  assign pcSrcE = pc_src;
  assign stallF = lw_stall;
  assign stallD = lw_stall;
  assign flushD = pc_src;
  assign flushE = lw_stall | pc_src;

  assign regWriteE   = idex_q.reg_write;
  assign resultSrcE  = idex_q.result_src;
  assign memWriteE   = idex_q.mem_write;
  assign aluControlE = idex_q.alu_control;
  assign aluSrcE     = idex_q.alu_src;
  assign rs1E        = idex_q.rs1;
  assign rs2E        = idex_q.rs2;
  assign rdE         = idex_q.rd;
  assign regWriteM   = exmem_q.reg_write;
  assign resultSrcM  = exmem_q.result_src;
  assign memWriteM   = exmem_q.mem_write;
  assign rdM         = exmem_q.rd;
  assign regWriteW   = memwb_q.reg_write;
  assign resultSrcW  = memwb_q.result_src;
  assign rdW         = memwb_q.rd;

`ifdef RISC_PIPE_PERF_EN
  logic [PERF_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_d, flush_cnt_q;
  logic [PERF_W-1:0] retire_cnt_d, retire_cnt_q;

  // Counters wrap naturally at 2^PERF_W.
  always_comb begin
    stall_cnt_d  = stall_cnt_q  + {{(PERF_W-1){1'b0}}, lw_stall};
    flush_cnt_d  = flush_cnt_q  + {{(PERF_W-1){1'b0}}, pc_src};
    retire_cnt_d = retire_cnt_q + {{(PERF_W-1){1'b0}}, memwb_q.reg_write | memwb_q.vld};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign stallCnt  = stall_cnt_q;
  assign flushCnt  = flush_cnt_q;
  assign retireCnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_risc_pipe_ctrl.sv
// Scoreboard bench for risc_pipe_ctrl: directed instruction stream, expected per-cycle outputs queued
// by the driver and compared by a negedge monitor.
module tb_risc_pipe_ctrl;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          regWriteD, memWriteD, branchD, jumpD, aluSrcD, zeroE;
  logic [1:0]    resultSrcD;
  logic [2:0]    aluControlD;
  logic [AW-1:0] rs1D, rs2D, rdD;
  logic          regWriteE, memWriteE, aluSrcE, regWriteM, memWriteM, regWriteW;
  logic [1:0]    resultSrcE, resultSrcM, resultSrcW, forwardAE, forwardBE;
  logic [2:0]    aluControlE;
  logic [AW-1:0] rs1E, rs2E, rdE, rdM, rdW;
  logic          pcSrcE, stallF, stallD, flushD, flushE;
`ifdef RISC_PIPE_PERF_EN
  logic [31:0]   stallCnt, flushCnt, retireCnt;
`endif

  risc_pipe_ctrl #(.REG_AW(AW), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
`ifdef RISC_PIPE_PERF_EN
    .stallCnt(stallCnt), .flushCnt(flushCnt), .retireCnt(retireCnt),
`endif
    .regWriteD(regWriteD), .resultSrcD(resultSrcD), .memWriteD(memWriteD),
    .branchD(branchD), .jumpD(jumpD), .aluControlD(aluControlD), .aluSrcD(aluSrcD),
    .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .zeroE(zeroE),
    .regWriteE(regWriteE), .resultSrcE(resultSrcE), .memWriteE(memWriteE),
    .aluControlE(aluControlE), .aluSrcE(aluSrcE), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .regWriteM(regWriteM), .resultSrcM(resultSrcM), .memWriteM(memWriteM), .rdM(rdM),
    .regWriteW(regWriteW), .resultSrcW(resultSrcW), .rdW(rdW),
    .pcSrcE(pcSrcE), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .forwardAE(forwardAE), .forwardBE(forwardBE)
  );

  typedef struct packed {
    logic rw; logic [1:0] rs; logic mw, br, jp;
    logic [AW-1:0] rs1, rs2, rd;
  } ins_t;

  // hz = {pcSrcE, stallF, stallD, flushD, flushE}
  typedef struct packed {
    logic [4:0] hz; logic [1:0] fa, fb;
    logic rwE, mwE; logic [AW-1:0] rdE;
    logic rwM; logic [AW-1:0] rdM;
    logic rwW; logic [AW-1:0] rdW;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  function automatic ins_t ins(input logic rw, input logic [1:0] rs, input logic mw,
                               input logic br, input logic jp, input int s1, input int s2, input int d);
    ins_t i;
    i = '{rw, rs, mw, br, jp, AW'(s1), AW'(s2), AW'(d)};
    return i;
  endfunction

  function automatic exp_t ex(input logic [4:0] hz, input logic [1:0] fa, input logic [1:0] fb,
                              input logic rwE, input logic mwE, input int rdE_,
                              input logic rwM, input int rdM_, input logic rwW, input int rdW_);
    exp_t e;
    e = '{hz, fa, fb, rwE, mwE, AW'(rdE_), rwM, AW'(rdM_), rwW, AW'(rdW_)};
    return e;
  endfunction

  // ALU control / src ride along derived from rd so the bench can predict their EX copies.
  task automatic cyc(input logic r, input ins_t i, input logic z, input exp_t e);
    rst = r;
    regWriteD = i.rw; resultSrcD = i.rs; memWriteD = i.mw; branchD = i.br; jumpD = i.jp;
    rs1D = i.rs1; rs2D = i.rs2; rdD = i.rd; aluControlD = i.rd[2:0]; aluSrcD = i.rd[0];
    zeroE = z;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  exp_t m;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m = exp_q.pop_front();
      chk("hazards{pc,sF,sD,fD,fE}", {pcSrcE, stallF, stallD, flushD, flushE}, m.hz);
      chk("forwardAE", forwardAE, m.fa);
      chk("forwardBE", forwardBE, m.fb);
      chk("regWriteE", regWriteE, m.rwE);
      chk("memWriteE", memWriteE, m.mwE);
      chk("rdE", rdE, m.rdE);
      chk("aluControlE", aluControlE, m.rdE[2:0]);
      chk("aluSrcE", aluSrcE, m.rdE[0]);
      chk("regWriteM", regWriteM, m.rwM);
      chk("rdM", rdM, m.rdM);
      chk("regWriteW", regWriteW, m.rwW);
      chk("rdW", rdW, m.rdW);
    end
  end

  ins_t nop, lw5, add6_5, add3, sub4, add8, or9, sub10, add0, add12, add7, add11, beq, sw, synth;
  localparam logic [4:0] H0 = 5'b00000, HLW = 5'b01101, HBR = 5'b10011, HALL = 5'b11111;

  initial begin
    nop    = ins(0, 2'b00, 0, 0, 0, 0, 0, 0);
    lw5    = ins(1, 2'b01, 0, 0, 0, 1, 0, 5);
    add6_5 = ins(1, 2'b00, 0, 0, 0, 5, 2, 6);
    add3   = ins(1, 2'b00, 0, 0, 0, 1, 2, 3);
    sub4   = ins(1, 2'b00, 0, 0, 0, 7, 3, 4);
    add8   = ins(1, 2'b00, 0, 0, 0, 1, 1, 8);
    or9    = ins(1, 2'b00, 0, 0, 0, 0, 0, 9);
    sub10  = ins(1, 2'b00, 0, 0, 0, 0, 8, 10);
    add0   = ins(1, 2'b00, 0, 0, 0, 0, 0, 0);
    add12  = ins(1, 2'b00, 0, 0, 0, 0, 0, 12);
    add7   = ins(1, 2'b00, 0, 0, 0, 0, 0, 7);
    add11  = ins(1, 2'b00, 0, 0, 0, 7, 0, 11);
    beq    = ins(0, 2'b00, 0, 1, 0, 1, 2, 0);
    sw     = ins(0, 2'b00, 1, 0, 0, 3, 4, 0);
    synth  = ins(1, 2'b01, 0, 0, 1, 0, 0, 5);

    // Reset with junk on the D inputs: first cycle unchecked, second must be all-zero.
    rst = 1'b1;
    regWriteD = 1'b1; resultSrcD = 2'b01; memWriteD = 1'b1; branchD = 1'b1; jumpD = 1'b1;
    aluControlD = 3'($urandom); aluSrcD = 1'b1; zeroE = 1'b1;
    rs1D = AW'($urandom); rs2D = AW'($urandom); rdD = AW'($urandom);
    @(posedge clk); #1;
    cyc(1, ins(1, 2'b01, 1, 1, 1, 9, 9, 9), 1, ex(H0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef RISC_PIPE_PERF_EN
    chk("stallCnt@reset", stallCnt, 0);
    chk("flushCnt@reset", flushCnt, 0);
    chk("retireCnt@reset", retireCnt, 0);
`endif
    // load-use: one stall cycle, bubble, then consumer with WB forward
    cyc(0, lw5,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, add6_5, 0, ex(HLW, 0,     0,     1, 0, 5,  0, 0,  0, 0));
    cyc(0, add6_5, 0, ex(H0,  0,     0,     0, 0, 0,  1, 5,  0, 0));
    cyc(0, nop,    0, ex(H0,  2'b01, 0,     1, 0, 6,  0, 0,  1, 5));
    // MEM forward, then WB forward across an unrelated instruction
    cyc(0, add3,   0, ex(H0,  0,     0,     0, 0, 0,  1, 6,  0, 0));
    cyc(0, sub4,   0, ex(H0,  0,     0,     1, 0, 3,  0, 0,  1, 6));
    cyc(0, add8,   0, ex(H0,  0,     2'b10, 1, 0, 4,  1, 3,  0, 0));
    cyc(0, or9,    0, ex(H0,  0,     0,     1, 0, 8,  1, 4,  1, 3));
    cyc(0, sub10,  0, ex(H0,  0,     0,     1, 0, 9,  1, 8,  1, 4));
    cyc(0, nop,    0, ex(H0,  0,     2'b01, 1, 0, 10, 1, 9,  1, 8));
    // x0 never forwarded; MEM wins over WB on the same rd
    cyc(0, add0,   0, ex(H0,  0,     0,     0, 0, 0,  1, 10, 1, 9));
    cyc(0, add12,  0, ex(H0,  0,     0,     1, 0, 0,  0, 0,  1, 10));
    cyc(0, nop,    0, ex(H0,  0,     0,     1, 0, 12, 1, 0,  0, 0));
    cyc(0, add7,   0, ex(H0,  0,     0,     0, 0, 0,  1, 12, 1, 0));
    cyc(0, add7,   0, ex(H0,  0,     0,     1, 0, 7,  0, 0,  1, 12));
    cyc(0, add11,  0, ex(H0,  0,     0,     1, 0, 7,  1, 7,  0, 0));
    cyc(0, nop,    0, ex(H0,  2'b10, 0,     1, 0, 11, 1, 7,  1, 7));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  1, 11, 1, 7));
    // taken branch flushes wrong-path store; zeroE alone does nothing
    cyc(0, beq,    1, ex(H0,  0,     0,     0, 0, 0,  0, 0,  1, 11));
    cyc(0, sw,     1, ex(HBR, 0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    // not-taken branch: store proceeds to EX
    cyc(0, beq,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, sw,     0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 1, 0,  0, 0,  0, 0));
    // simultaneous load-use and jump
    cyc(0, synth,  0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, add6_5, 0, ex(HALL, 0,    0,     1, 0, 5,  0, 0,  0, 0));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  1, 5,  0, 0));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  1, 5));
`ifdef RISC_PIPE_PERF_EN
    chk("stallCnt", stallCnt, 2);
    chk("flushCnt", flushCnt, 2);
    chk("retireCnt", retireCnt, 23);
`endif
    // mid-flight reset squashes the load sitting in EX
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, lw5,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(1, nop,    0, ex(H0,  0,     0,     1, 0, 5,  0, 0,  0, 0));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));
    cyc(0, nop,    0, ex(H0,  0,     0,     0, 0, 0,  0, 0,  0, 0));

    @(posedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
